// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle execute controller for the 16-bit ALU; reads operands, runs the ALU,
// then commits to the register file, PC, memory or the C/N/V/Z flag register.
module alu_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_op,
  input  logic [3:0]  instr_rd,
  input  logic [3:0]  instr_rs,
  input  logic [3:0]  instr_rt,
  input  logic [15:0] instr_imm,
  input  logic        instr_use_imm,
  input  logic        instr_setf,
  input  logic        instr_carry,
  output logic [3:0]  rf_raddr0,
  output logic [3:0]  rf_raddr1,
  input  logic [15:0] rf_rdata0,
  input  logic [15:0] rf_rdata1,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [3:0]  alu_func,
  output logic [15:0] alu_op0,
  output logic [15:0] alu_op1,
  output logic        alu_flag_en,
  output logic [3:0]  alu_flag_in,
  input  logic [15:0] alu_q,
  input  logic [3:0]  alu_flag_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        done,
  output logic        mem_err
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;
  state_t      state;
  logic [3:0]  op, rd;
  logic [15:0] imm, sdata, wcnt;
  logic        use_imm, setf, carry, is_alu, br_ok;
  logic [1:0]  ecnt;
  assign instr_ready = state == IDLE || state == WB;
  assign busy = state != IDLE;
  assign is_alu = op >= 4'h1 && op <= 4'h7;
  // flags are {C,N,V,Z}; branches resolve against the flags as they stand at EXEC exit
  assign br_ok = op == 4'hB ? flags[0] :
                 op == 4'hC ? !flags[0] :
                 op == 4'hD ? flags[2] && !flags[0] :
                 op == 4'hE ? !flags[2] && !flags[0] : 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      rd <= '0;
      imm <= '0;
      sdata <= '0;
      wcnt <= '0;
      use_imm <= 1'b0;
      setf <= 1'b0;
      carry <= 1'b0;
      ecnt <= '0;
      rf_raddr0 <= '0;
      rf_raddr1 <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      alu_func <= '0;
      alu_op0 <= '0;
      alu_op1 <= '0;
      alu_flag_en <= 1'b0;
      alu_flag_in <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      pc_load <= 1'b0;
      pc_target <= '0;
      flags <= '0;
      done <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      pc_load <= 1'b0;
      done <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        IDLE, WB:
          if (instr_valid) begin
            op <= instr_op;
            rd <= instr_rd;
            imm <= instr_imm;
            use_imm <= instr_use_imm;
            setf <= instr_setf;
            carry <= instr_carry;
            rf_raddr0 <= instr_rs;
            rf_raddr1 <= instr_op == 4'h9 ? instr_rd : instr_rt;
            state <= READ;
          end else state <= IDLE;
        READ: begin
          alu_func <= op;
          alu_op0 <= rf_rdata0;
          alu_op1 <= (use_imm || op == 4'h9) ? imm : rf_rdata1;
          sdata <= rf_rdata1;
          alu_flag_en <= is_alu ? setf : op == 4'hF;
          alu_flag_in <= {carry & flags[3], flags[2:0]};
          ecnt <= '0;
          state <= EXEC;
        end
        EXEC:
          if (ecnt != 2'(EXEC_CYCLES - 1)) ecnt <= ecnt + 2'd1;
          else if (op == 4'h8 || op == 4'h9) begin
            mem_req <= 1'b1;
            mem_we <= op == 4'h9;
            mem_addr <= alu_q;
            mem_wdata <= sdata;
            wcnt <= '0;
            state <= MEM;
          end else begin
            done <= 1'b1;
            rf_we <= is_alu || op == 4'hA;
            rf_waddr <= rd;
            rf_wdata <= alu_q;
            pc_load <= op == 4'h0 || br_ok;
            pc_target <= op == 4'h0 ? alu_q : alu_op0;
            flags <= ((is_alu && setf) || op == 4'hF) ? alu_flag_out : flags;
            state <= WB;
          end
        MEM:
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            done <= 1'b1;
            rf_we <= op == 4'h8;
            rf_waddr <= rd;
            rf_wdata <= mem_rdata;
            state <= WB;
          end else if (MEM_TIMEOUT != 0 && wcnt == 16'(MEM_TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            done <= 1'b1;
            mem_err <= 1'b1;
            state <= WB;
          end else wcnt <= wcnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; the reference model retires each instruction at acceptance,
// a monitor pops expectations on every done pulse and a memory responder checks each request.
module tb_alu_sequencer;
  localparam int EC = 3;
  localparam int MT = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid = 1'b0, instr_ready;
  logic [3:0] instr_op = '0, instr_rd = '0, instr_rs = '0, instr_rt = '0;
  logic [15:0] instr_imm = '0;
  logic instr_use_imm = 1'b0, instr_setf = 1'b0, instr_carry = 1'b0;
  logic [3:0] rf_raddr0, rf_raddr1, rf_waddr, alu_func, alu_flag_in, alu_flag_out, flags;
  logic [15:0] rf_rdata0, rf_rdata1, rf_wdata, alu_op0, alu_op1, alu_q;
  logic [15:0] mem_addr, mem_wdata, pc_target;
  logic [15:0] mem_rdata = '0;
  logic rf_we, alu_flag_en, mem_req, mem_we, pc_load, busy, done, mem_err;
  logic mem_ack = 1'b0;
  logic rf_init = 1'b1;
  logic [15:0] rf_mem [16];
  logic [15:0] init_val [16];
  logic [15:0] ref_rf [16];
  logic [3:0] ref_fl = '0;
  int cyc = 0, checks = 0, failures = 0, mcount = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        pl;
    logic        cp;
    logic [15:0] pt;
    logic        me;
    logic [3:0]  fl;
    logic [3:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic        fen;
  } exp_t;
  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wd;
    logic [2:0]  d;
    logic [15:0] rd;
  } mem_t;
  exp_t exp_q[$];
  mem_t mem_q[$];
  mem_t cur;

  alu_sequencer #(.EXEC_CYCLES(EC), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_imm(instr_imm), .instr_use_imm(instr_use_imm), .instr_setf(instr_setf),
    .instr_carry(instr_carry), .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .alu_func(alu_func), .alu_op0(alu_op0), .alu_op1(alu_op1),
    .alu_flag_en(alu_flag_en), .alu_flag_in(alu_flag_in), .alu_q(alu_q),
    .alu_flag_out(alu_flag_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc_load(pc_load),
    .pc_target(pc_target), .flags(flags), .busy(busy), .done(done), .mem_err(mem_err)
  );

  // ALU behaviour shared by the stub and the reference: {C,N,V,Z,Q}; address ops add op0+op1
  function automatic logic [19:0] alu_calc(input logic [3:0] f, input logic [15:0] a, b, input logic [3:0] fi);
    logic [16:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (f)
      4'd1: begin r = {1'b0, a} + {1'b0, b} + 17'(fi[3]); c = r[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd2, 4'd15: begin r = {1'b0, a} - {1'b0, b} - 17'(fi[3]); c = r[16]; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd3: r = {1'b0, a << b[3:0]};
      4'd4: r = {1'b0, a >> b[3:0]};
      4'd5: r = {1'b0, a & b};
      4'd6: r = {1'b0, a | b};
      4'd7: r = {1'b0, a ^ b};
      4'd0, 4'd8, 4'd9: r = {1'b0, a + b};
      4'd10: r = {1'b0, b};
      default: r = {1'b0, a};
    endcase
    return {c, r[15], v, r[15:0] == 16'd0, r[15:0]};
  endfunction

  assign {alu_flag_out, alu_q} = alu_calc(alu_func, alu_op0, alu_op1, alu_flag_in);
  assign rf_rdata0 = rf_mem[rf_raddr0];
  assign rf_rdata1 = rf_mem[rf_raddr1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (rf_init) for (int i = 0; i < 16; i++) rf_mem[i] <= init_val[i];
    else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // retirement monitor
  always @(negedge clk)
    if (rst_n) begin
      exp_t e;
      chk("stray_strobe", 32'({rf_we, pc_load, mem_err} & {3{~done}}), 32'd0);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), e.cyc);
          chk("rf_we", 32'(rf_we), 32'(e.we));
          if (e.we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.wd));
          end
          chk("pc_load", 32'(pc_load), 32'(e.pl));
          if (e.cp) chk("pc_target", 32'(pc_target), 32'(e.pt));
          chk("mem_err", 32'(mem_err), 32'(e.me));
          chk("flags", 32'(flags), 32'(e.fl));
          chk("alu_func", 32'(alu_func), 32'(e.func));
          chk("alu_op0", 32'(alu_op0), 32'(e.a));
          chk("alu_op1", 32'(alu_op1), 32'(e.b));
          chk("alu_flag_en", 32'(alu_flag_en), 32'(e.fen));
        end
      end
    end

  // memory responder: acks in MEM cycle d (d=0 never acks) and checks the request
  always @(negedge clk)
    if (!rst_n) begin
      mcount = 0;
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (mcount == 0) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
          cur = '0;
        end else begin
          cur = mem_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wd));
        end
      end
      mcount++;
      chk("mem_req_len", 32'(mcount <= (cur.d == 3'd0 ? MT : int'(cur.d))), 32'd1);
      mem_ack = cur.d != 3'd0 && mcount == int'(cur.d);
      mem_rdata = cur.rd;
    end else begin
      mcount = 0;
      mem_ack = 1'b0;
    end

  task automatic issue(input logic [3:0] op, rd, rs, rt, input logic [15:0] imm,
                       input logic ui, sf, cy, input int md, input logic [15:0] mrd);
    int n = 0;
    exp_t e;
    logic [15:0] a, b, sd;
    logic [19:0] r;
    int lat;
    @(negedge clk);
    instr_valid = 1'b1;
    {instr_op, instr_rd, instr_rs, instr_rt} = {op, rd, rs, rt};
    {instr_imm, instr_use_imm, instr_setf, instr_carry} = {imm, ui, sf, cy};
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(instr_ready), 32'd1);
    if (!instr_ready) begin instr_valid = 1'b0; return; end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    a = ref_rf[rs];
    b = (ui || op == 4'd9) ? imm : ref_rf[rt];
    sd = ref_rf[rd];
    r = alu_calc(op, a, b, {cy & ref_fl[3], ref_fl[2:0]});
    e = '0;
    e.func = op;
    e.a = a;
    e.b = b;
    e.fen = (op >= 4'd1 && op <= 4'd7) ? sf : op == 4'd15;
    e.wa = rd;
    lat = 1 + EC;
    if (op inside {[4'd1:4'd7], 4'd10}) begin
      e.we = 1'b1;
      e.wd = r[15:0];
      if (op != 4'd10 && sf) ref_fl = r[19:16];
    end
    if (op == 4'd15) ref_fl = r[19:16];
    if (op == 4'd0) begin e.pl = 1'b1; e.cp = 1'b1; e.pt = r[15:0]; end
    if (op >= 4'd11 && op <= 4'd14) begin
      e.cp = 1'b1;
      e.pt = a;
      e.pl = op == 4'd11 ? ref_fl[0] : op == 4'd12 ? !ref_fl[0] :
             op == 4'd13 ? ref_fl[2] && !ref_fl[0] : !ref_fl[2] && !ref_fl[0];
    end
    if (op == 4'd8 || op == 4'd9) begin
      mem_q.push_back({r[15:0], op == 4'd9, sd, 3'(md), mrd});
      lat += md == 0 ? MT : md;
      if (md == 0) e.me = 1'b1;
      else if (op == 4'd8) begin e.we = 1'b1; e.wd = mrd; end
    end
    if (e.we) ref_rf[rd] = e.wd;
    e.fl = ref_fl;
    e.cyc = 32'(cyc + lat);
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      init_val[i] = 16'($urandom);
      ref_rf[i] = init_val[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_strobes", 32'({rf_we, mem_req, mem_we, pc_load, done, mem_err, busy}), 32'd0);
    chk("reset_data", 32'({rf_wdata, mem_addr} | {mem_wdata, pc_target}), 32'd0);
    chk("reset_flags", 32'({flags, alu_func, alu_flag_in}), 32'd0);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rf_init = 1'b0;
    issue(4'hA, 4'd1, 4'd0, 4'd0, 16'h0003, 1, 0, 0, 0, 0);
    issue(4'hA, 4'd2, 4'd0, 4'd0, 16'h0004, 1, 0, 0, 0, 0);
    issue(4'h1, 4'd3, 4'd1, 4'd2, 16'h0000, 0, 1, 0, 0, 0);
    issue(4'hA, 4'd1, 4'd0, 4'd0, 16'h0005, 1, 0, 0, 0, 0);
    issue(4'hA, 4'd2, 4'd0, 4'd0, 16'h0005, 1, 0, 0, 0, 0);
    issue(4'hA, 4'd4, 4'd0, 4'd0, 16'h0040, 1, 0, 0, 0, 0);
    issue(4'hF, 4'd0, 4'd1, 4'd2, 16'h0000, 0, 0, 0, 0, 0);
    issue(4'hB, 4'd0, 4'd4, 4'd0, 16'h0000, 0, 0, 0, 0, 0);
    issue(4'hC, 4'd0, 4'd4, 4'd0, 16'h0000, 0, 0, 0, 0, 0);
    issue(4'hA, 4'd5, 4'd0, 4'd0, 16'h0100, 1, 0, 0, 0, 0);
    issue(4'h8, 4'd6, 4'd5, 4'd0, 16'h0004, 1, 0, 0, 3, 16'hBEEF);
    issue(4'h9, 4'd6, 4'd5, 4'd0, 16'h0008, 1, 0, 0, 0, 0);
    issue(4'hA, 4'd7, 4'd0, 4'd0, 16'h0010, 1, 0, 0, 0, 0);
    issue(4'h2, 4'd8, 4'd7, 4'd0, 16'h0001, 1, 1, 0, 0, 0);
    drain();
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(1, 3)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    issue(4'hA, 4'd1, 4'd0, 4'd0, 16'h0005, 1, 0, 0, 0, 0);
    issue(4'hF, 4'd0, 4'd1, 4'd0, 16'h0005, 1, 0, 0, 0, 0);
    issue(4'h8, 4'd9, 4'd1, 4'd0, 16'h0000, 1, 0, 0, 0, 0);
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
    chk("mem_req_seen", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", 32'({mem_req, busy, done}), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    exp_q.delete();
    mem_q.delete();
    ref_fl = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'h1, 4'd10, 4'd1, 4'd0, 16'h0002, 1, 1, 0, 0, 0);
    drain();
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
